shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have port clk  input  1  single core clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port req_i  input  1  start request from decode for an I-type shift.
REQ-004 SHALL have port funct3_i  input  3  shift kind: 3'b001 = SLLI, 3'b101 = SRLI/SRAI.
REQ-005 SHALL have port arith_i  input  1  funct7[5]; 1 selects SRAI when funct3_i = 3'b101.
REQ-006 SHALL have port op1_i  input  `RDATA_WIDTH  operand (rs1 data).
REQ-007 SHALL have port op2_i  input  `RDATA_WIDTH  shift amount; only bits [4:0] used.
REQ-008 SHALL have port rd_i  input  `RADDR_WIDTH  destination register.
REQ-009 SHALL have port flush_i  input  1  abort current operation.
REQ-010 SHALL have port stall_o  output  1  hold upstream pipeline.
REQ-011 SHALL have port busy_o  output  1  state != IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports result_o  output  `RDATA_WIDTH, reg_we_o  output  1, reg_waddr_o  output  `RADDR_WIDTH: writeback.

Function
REQ-014 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-015 SHALL accept a request in IDLE when req_i = 1, flush_i = 0 and the kind is legal; on acceptance it captures op1_i, op2_i[4:0] (count), direction, arith and rd_i.
REQ-016 SHALL treat funct3_i other than 001/101, and funct3_i = 001 with arith_i = 1, as illegal: no capture, remain IDLE, stall_o = 0.
REQ-017 SHALL, on acceptance, go to DONE if count = 0, else to SHIFT.
REQ-018 SHALL, in SHIFT, shift the held value by one bit per cycle (left with zero fill; logical right with zero fill; arithmetic right with sign fill) and decrement count; go to DONE on the cycle count reaches 0.
REQ-019 SHALL, in DONE, drive done_o = 1, reg_we_o = 1, reg_waddr_o = captured rd, result_o = shifted value for exactly one cycle, then return to IDLE.
REQ-020 SHALL drive result_o, reg_waddr_o to zero and reg_we_o, done_o to 0 outside DONE.
REQ-021 SHALL drive stall_o combinationally = (IDLE and legal accepted request) or SHIFT; stall_o = 0 in DONE.
REQ-022 SHALL give latency shamt+1 cycles from acceptance edge to done_o (shamt = 0 -> 1 cycle).
REQ-023 SHALL ignore req_i while in SHIFT or DONE.
REQ-024 SHALL, on flush_i = 1 in any state, go to IDLE next cycle with no done_o/reg_we_o; flush_i together with req_i in IDLE SHALL win (no acceptance, stall_o = 0).
REQ-025 SHALL accept a new request in the cycle immediately after DONE (back-to-back).

Reset
REQ-026 SHALL, when rst = 0 at a clock edge, enter IDLE and clear count, held value and captured rd to zero, overriding req_i and flush_i.
REQ-027 SHALL drive all outputs 0 while in reset and the cycle after; reset mid-SHIFT SHALL drop the operation without writeback.

Configuration
REQ-028 SHALL honour macro SHIFT_SEQ_FAST_EN: when defined, SHIFT moves 4 bits per cycle while count >= 4 and 1 bit otherwise (latency floor(shamt/4) + shamt mod 4 + 1); when undefined, 1 bit per cycle per REQ-018. Results SHALL be identical in both builds.

Verification
REQ-029 SHALL cover SLLI: op1 = 32'h0000_0001, shamt 4, rd 5 -> done_o 5 cycles after acceptance, result_o = 32'h0000_0010, reg_waddr_o = 5 (FAST: 2 cycles).
REQ-030 SHALL cover SRAI: op1 = 32'h8000_0000, shamt 31, arith 1 -> result_o = 32'hFFFF_FFFF; SRLI same operand -> 32'h0000_0001.
REQ-031 SHALL cover shamt 0: op1 = 32'hDEAD_BEEF -> done_o next cycle, result_o = 32'hDEAD_BEEF, stall_o high only in acceptance cycle.
REQ-032 SHALL cover illegal request: funct3 3'b001, arith 1 -> stall_o = 0, busy_o stays 0, no done_o.
REQ-033 SHALL cover flush at 3rd SHIFT cycle of shamt 10 -> IDLE next cycle, no reg_we_o; new request accepted immediately after.
REQ-034 SHALL cover rst = 0 mid-SHIFT -> IDLE, all outputs 0, no writeback; back-to-back requests after DONE both complete correctly.

Source files
------------

// File: rtl/shift_seq.sv
// Sequential I-type shifter (SLLI/SRLI/SRAI): captures an operand, shifts it a few bits per cycle, writes back once.
// Optional build macro SHIFT_SEQ_FAST_EN: shift 4 bits per cycle while the remaining count is at least 4.

`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

module shift_seq (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    input  logic [2:0]                funct3_i,
    input  logic                      arith_i,
    input  logic [`RDATA_WIDTH-1:0]   op1_i,
    input  logic [`RDATA_WIDTH-1:0]   op2_i,
    input  logic [`RADDR_WIDTH-1:0]   rd_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [`RDATA_WIDTH-1:0]   result_o,
    output logic                      reg_we_o,
    output logic [`RADDR_WIDTH-1:0]   reg_waddr_o
);

    localparam int unsigned DW = `RDATA_WIDTH;
    localparam int unsigned AW = `RADDR_WIDTH;
    localparam int unsigned CW = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] val_q,   val_d;
    logic [AW-1:0] rd_q,    rd_d;
    logic          right_q, right_d;
    logic          arith_q, arith_d;

    logic          legal;
    logic          accept;
    logic [2:0]    step;
    logic          unused_op2_hi;

    // Only the low five bits of the shift operand carry the amount.
    assign unused_op2_hi = ^op2_i[DW-1:CW];

    assign legal  = ((funct3_i == F3_SLL) && !arith_i) || (funct3_i == F3_SR);
    assign accept = rst && (state_q == ST_IDLE) && req_i && !flush_i && legal;

`ifdef SHIFT_SEQ_FAST_EN
    assign step = (cnt_q >= CW'(4)) ? 3'd4 : 3'd1;
`else
    assign step = 3'd1;
`endif

    // One shift step of amt bits in the captured direction/fill.
    function automatic logic [DW-1:0] shift_step(input logic [DW-1:0] v,
                                                 input logic          right,
                                                 input logic          arith,
                                                 input logic [2:0]    amt);
        logic [DW-1:0] r;
        if (!right) begin
            r = v << amt;
        end else if (arith) begin
            r = DW'($signed(v) >>> amt);
        end else begin
            r = v >> amt;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            rd_q    <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            rd_q    <= rd_d;
            right_q <= right_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        rd_d    = rd_q;
        right_d = right_q;
        arith_d = arith_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = op2_i[CW-1:0];
                    val_d   = op1_i;
                    rd_d    = rd_i;
                    right_d = (funct3_i == F3_SR);
                    arith_d = arith_i && (funct3_i == F3_SR);
                    state_d = (op2_i[CW-1:0] == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                val_d = shift_step(val_q, right_q, arith_q, step);
                cnt_d = cnt_q - CW'(step);
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush aborts from any state; acceptance is already blocked by it.
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs decode the state register; held at zero while reset is asserted.
    always_comb begin
        stall_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        reg_we_o    = 1'b0;
        result_o    = '0;
        reg_waddr_o = '0;
        if (rst) begin
            stall_o = accept || (state_q == ST_SHIFT);
            busy_o  = (state_q != ST_IDLE);
            if (state_q == ST_DONE) begin
                done_o      = 1'b1;
                reg_we_o    = 1'b1;
                result_o    = val_q;
                reg_waddr_o = rd_q;
            end
        end
    end

endmodule
